// File: rtl/register_dump_unit.sv
// Register-bank dump engine: scans every register through the sr1 read port and
// streams each word MSB-byte-first over a valid/ready link. Optional macro: REG_DUMP_CHECKSUM_EN.
module register_dump_unit #(
    parameter int NB_DATA     = 32,
    parameter int NB_ADDRESS  = 5,
    parameter int N_REGISTERS = 32,
    parameter int NB_BYTE     = 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    output logic [NB_ADDRESS-1:0] o_sr_addr,
    input  logic [NB_DATA-1:0]    i_sr_data,
    output logic [NB_BYTE-1:0]    o_tx_data,
    output logic                  o_tx_valid,
    input  logic                  i_tx_ready,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int BYTES_PER_REG = NB_DATA / NB_BYTE;
    localparam int CNT_W         = (BYTES_PER_REG > 1) ? $clog2(BYTES_PER_REG) : 1;
    localparam logic [CNT_W-1:0]      LAST_BYTE = CNT_W'(BYTES_PER_REG - 1);
    localparam logic [NB_ADDRESS-1:0] LAST_ADDR = NB_ADDRESS'(N_REGISTERS - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_SEND = 3'd2,
`ifdef REG_DUMP_CHECKSUM_EN
        S_CHK  = 3'd3,
`endif
        S_DONE = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [NB_ADDRESS-1:0] addr_q, addr_d;
    logic [NB_DATA-1:0]  shift_q, shift_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
`ifdef REG_DUMP_CHECKSUM_EN
    logic [NB_BYTE-1:0]  chk_q, chk_d;
`endif

    assign o_sr_addr = addr_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            shift_q <= '0;
            cnt_q   <= '0;
`ifdef REG_DUMP_CHECKSUM_EN
            chk_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
`ifdef REG_DUMP_CHECKSUM_EN
            chk_q   <= chk_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
`ifdef REG_DUMP_CHECKSUM_EN
        chk_d      = chk_q;
`endif
        o_tx_valid = 1'b0;
        o_tx_data  = '0;
        o_busy     = (state_q != S_IDLE);
        o_done     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    addr_d  = '0;
`ifdef REG_DUMP_CHECKSUM_EN
                    chk_d   = '0;
`endif
                    state_d = S_LOAD;
                end
            end
            // Bank read is combinational, so the word for addr_q is already valid here.
            S_LOAD: begin
                shift_d = i_sr_data;
                cnt_d   = '0;
                state_d = S_SEND;
            end
            S_SEND: begin
                o_tx_valid = 1'b1;
                o_tx_data  = shift_q[NB_DATA-1 -: NB_BYTE];
                if (i_tx_ready) begin
`ifdef REG_DUMP_CHECKSUM_EN
                    chk_d = chk_q ^ shift_q[NB_DATA-1 -: NB_BYTE];
`endif
                    if (cnt_q != LAST_BYTE) begin
                        shift_d = shift_q << NB_BYTE;
                        cnt_d   = cnt_q + 1'b1;
                    end else if (addr_q < LAST_ADDR) begin
                        addr_d  = addr_q + 1'b1;
                        state_d = S_LOAD;
                    end else begin
`ifdef REG_DUMP_CHECKSUM_EN
                        state_d = S_CHK;
`else
                        state_d = S_DONE;
`endif
                    end
                end
            end
`ifdef REG_DUMP_CHECKSUM_EN
            S_CHK: begin
                o_tx_valid = 1'b1;
                o_tx_data  = chk_q;
                if (i_tx_ready) state_d = S_DONE;
            end
`endif
            S_DONE: begin
                o_done  = 1'b1;
                addr_d  = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_register_dump_unit.sv
// Directed bench for register_dump_unit: bank model, byte collector and per-scenario tasks.
module tb_register_dump_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  sr_addr;
    logic [31:0] sr_data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    register_dump_unit dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_start    (start),
        .o_sr_addr  (sr_addr),
        .i_sr_data  (sr_data),
        .o_tx_data  (tx_data),
        .o_tx_valid (tx_valid),
        .i_tx_ready (tx_ready),
        .o_busy     (busy),
        .o_done     (done)
    );

`ifdef REG_DUMP_CHECKSUM_EN
    localparam int EXP_LEN     = 129;
    localparam int EXP_DONE_AT = 162;
`else
    localparam int EXP_LEN     = 128;
    localparam int EXP_DONE_AT = 161;
`endif

    logic [31:0] mem [32];
    assign sr_data = mem[sr_addr];

    int total = 0;
    int bad   = 0;

    logic [7:0] xq[$];
    logic [7:0] exp_q[$];
    int  done_cnt, busy_cyc, done_at, viol, max_addr;
    bit  seen_nz, wrapped;
    logic prev_stall = 1'b0;
    logic prev_rst   = 1'b0;
    logic [7:0] prev_data = 8'h00;

    // Collector sampled on the falling edge, i.e. the values the next rising edge will see.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && !prev_rst) begin
                if (!tx_valid || tx_data !== prev_data) viol++;
            end
            if (tx_valid && tx_ready) xq.push_back(tx_data);
            if (busy) begin
                busy_cyc++;
                if (int'(sr_addr) > max_addr) max_addr = int'(sr_addr);
                if (sr_addr != 5'd0) seen_nz = 1'b1;
                else if (seen_nz) wrapped = 1'b1;
            end
            if (done) begin
                done_cnt++;
                done_at = busy_cyc;
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
        end
        prev_rst = rst;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    task automatic clear_mon();
        xq.delete();
        done_cnt = 0; busy_cyc = 0; done_at = 0; viol = 0; max_addr = 0;
        seen_nz = 1'b0; wrapped = 1'b0;
    endtask

    task automatic fill_kpattern();
        exp_q.delete();
        for (int k = 0; k < 32; k++) begin
            mem[k] = {8'(k), 8'(k + 1), 8'(k + 2), 8'(k + 3)};
            for (int j = 0; j < 4; j++) exp_q.push_back(8'(k + j));
        end
`ifdef REG_DUMP_CHECKSUM_EN
        begin
            logic [7:0] x = 8'h00;
            for (int i = 0; i < 128; i++) x ^= exp_q[i];
            exp_q.push_back(x);
        end
`endif
    endtask

    function automatic int stream_diff();
        int n = 0;
        int m = (xq.size() < exp_q.size()) ? xq.size() : exp_q.size();
        for (int i = 0; i < m; i++) if (xq[i] !== exp_q[i]) n++;
        return n + ((xq.size() > exp_q.size()) ? xq.size() - exp_q.size() : exp_q.size() - xq.size());
    endfunction

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; tx_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // mode 0: ready held high; 1: ready pattern 1,0,0,1; 2: ready high plus re-start at 10th transfer
    task automatic run_dump(input int mode, output bit timeout);
        bit pulsed = 1'b0;
        clear_mon();
        tx_ready = 1'b1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        timeout = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            if (mode == 1) tx_ready = ((c % 4) == 0) || ((c % 4) == 3);
            @(posedge clk); #1;
            if (mode == 2 && !pulsed && xq.size() == 10) begin
                start = 1'b1; pulsed = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done_cnt > 0) begin timeout = 1'b0; break; end
        end
        start = 1'b0; tx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b expected 0", tx_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %0b expected 0", done); end
        total++; if (sr_addr !== 5'd0) begin bad++; $display("FAIL reset_addr: got %0d expected 0", sr_addr); end
        total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %02h expected 00", tx_data); end
    endtask

    task automatic test_basic();
        bit to;
        int d;
        fill_kpattern();
        run_dump(0, to);
        d = stream_diff();
        total++; if (to !== 1'b0) begin bad++; $display("FAIL basic_timeout: got no done expected done"); end
        total++; if (xq.size() != EXP_LEN) begin bad++; $display("FAIL basic_len: got %0d expected %0d", xq.size(), EXP_LEN); end
        total++; if (d != 0) begin bad++; $display("FAIL basic_bytes: got %0d wrong bytes expected 0", d); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL basic_done_cnt: got %0d expected 1", done_cnt); end
        total++; if (done_at != EXP_DONE_AT) begin bad++; $display("FAIL basic_done_cycle: got %0d expected %0d", done_at, EXP_DONE_AT); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_after: got %0b expected 0", busy); end
        total++; if (xq.size() >= 4 && xq[4] !== 8'h01) begin bad++; $display("FAIL basic_byte4: got %02h expected 01", xq[4]); end
    endtask

    task automatic test_stall();
        bit to;
        int d;
        fill_kpattern();
        run_dump(1, to);
        d = stream_diff();
        total++; if (to !== 1'b0) begin bad++; $display("FAIL stall_timeout: got no done expected done"); end
        total++; if (xq.size() != EXP_LEN) begin bad++; $display("FAIL stall_len: got %0d expected %0d", xq.size(), EXP_LEN); end
        total++; if (d != 0) begin bad++; $display("FAIL stall_bytes: got %0d wrong bytes expected 0", d); end
        total++; if (viol != 0) begin bad++; $display("FAIL stall_stable: got %0d violations expected 0", viol); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL stall_done_cnt: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_restart_ignored();
        bit to;
        int d;
        fill_kpattern();
        run_dump(2, to);
        d = stream_diff();
        total++; if (xq.size() != EXP_LEN) begin bad++; $display("FAIL restart_len: got %0d expected %0d", xq.size(), EXP_LEN); end
        total++; if (d != 0) begin bad++; $display("FAIL restart_bytes: got %0d wrong bytes expected 0", d); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL restart_done_cnt: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_reset_mid();
        bit to = 1'b1;
        int d;
        fill_kpattern();
        clear_mon();
        tx_ready = 1'b1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            @(posedge clk); #1;
            if (xq.size() >= 50) begin to = 1'b0; break; end
        end
        total++; if (to !== 1'b0) begin bad++; $display("FAIL midrst_reach50: got %0d bytes expected 50", xq.size()); end
        rst = 1'b1;
        @(posedge clk); #1;
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %0b expected 0", tx_valid); end
        total++; if (sr_addr !== 5'd0) begin bad++; $display("FAIL midrst_addr: got %0d expected 0", sr_addr); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %0b expected 0", busy); end
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (done_cnt != 0) begin bad++; $display("FAIL midrst_no_done: got %0d expected 0", done_cnt); end
        run_dump(0, to);
        d = stream_diff();
        total++; if (xq.size() < 1 || xq[0] !== 8'h00) begin bad++; $display("FAIL midrst_first_byte: got %02h expected 00", (xq.size() > 0) ? xq[0] : 8'hxx); end
        total++; if (xq.size() != EXP_LEN) begin bad++; $display("FAIL midrst_len: got %0d expected %0d", xq.size(), EXP_LEN); end
        total++; if (d != 0) begin bad++; $display("FAIL midrst_bytes: got %0d wrong bytes expected 0", d); end
    endtask

    task automatic test_deadbeef();
        bit to;
        int d;
        logic [7:0] tail [4];
        tail[0] = 8'hDE; tail[1] = 8'hAD; tail[2] = 8'hBE; tail[3] = 8'hEF;
        exp_q.delete();
        for (int k = 0; k < 32; k++) mem[k] = 32'h0;
        mem[31] = 32'hDEADBEEF;
        for (int i = 0; i < 124; i++) exp_q.push_back(8'h00);
        for (int i = 0; i < 4; i++) exp_q.push_back(tail[i]);
`ifdef REG_DUMP_CHECKSUM_EN
        exp_q.push_back(8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF);
`endif
        run_dump(0, to);
        d = stream_diff();
        for (int i = 0; i < 4; i++) begin
            total++;
            if (xq.size() < 128 || xq[124 + i] !== tail[i]) begin
                bad++; $display("FAIL dead_tail%0d: got %02h expected %02h", i, (xq.size() >= 128) ? xq[124 + i] : 8'hxx, tail[i]);
            end
        end
        total++; if (d != 0) begin bad++; $display("FAIL dead_bytes: got %0d wrong bytes expected 0", d); end
        total++; if (max_addr != 31) begin bad++; $display("FAIL dead_max_addr: got %0d expected 31", max_addr); end
        total++; if (wrapped !== 1'b0) begin bad++; $display("FAIL dead_addr_wrap: got %0b expected 0", wrapped); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL dead_done_cnt: got %0d expected 1", done_cnt); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; tx_ready = 1'b0;
        for (int k = 0; k < 32; k++) mem[k] = 32'h0;
        test_reset();
        test_basic();
        test_stall();
        test_restart_ignored();
        test_reset_mid();
        test_deadbeef();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
